// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: collects one DATA_DEPTH x DATA_DEPTH block of raster pixels, kicks the transform
// pipeline, then streams its zigzag coefficients channel 0..CHANNELS-1, index 0..PIXEL_COUNT-1.
// Latency: pipe_start the cycle after the last pixel is taken; first coefficient the cycle after capture.
// Backpressure: s_ready low outside FILL; output beat holds while m_valid && !m_ready.
// Optional pipeline watchdog: define JPEG_SEQ_WATCHDOG_EN (otherwise err_timeout is tied low).
module jpeg_block_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int INPUT_WIDTH    = 8,
  parameter int DATA_DEPTH     = 8,
  parameter int CHANNELS       = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    s_valid,
  output logic                                                    s_ready,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]                         s_pixel,
  output logic                                                    pipe_start,
  output logic [CHANNELS*DATA_DEPTH*DATA_DEPTH*INPUT_WIDTH-1:0]   pipe_pix,
  input  logic                                                    pipe_done,
  input  logic                                                    pipe_valid,
  input  logic [CHANNELS*DATA_DEPTH*DATA_DEPTH*DATA_WIDTH-1:0]    pipe_coef,
  output logic                                                    m_valid,
  input  logic                                                    m_ready,
  output logic [DATA_WIDTH-1:0]                                   m_coef,
  output logic [1:0]                                              m_chan,
  output logic [$clog2(DATA_DEPTH*DATA_DEPTH)-1:0]                m_index,
  output logic                                                    m_last,
  output logic [15:0]                                             blocks_done,
  output logic                                                    err_timeout,
  output logic                                                    err_invalid
);

  localparam int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH;
  localparam int IDX_W       = $clog2(PIXEL_COUNT);
  localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [1:0]       LAST_CHAN = 2'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                                       state_q;
  logic                                         s_ready_q;
  logic                                         pipe_start_q;
  logic                                         m_valid_q;
  logic [IDX_W-1:0]                             pix_cnt_q;
  logic [IDX_W-1:0]                             idx_q, idx_d;
  logic [1:0]                                   chan_q, chan_d;
  logic [15:0]                                  blocks_q;
  logic                                         err_invalid_q;
  logic [CHANNELS*PIXEL_COUNT*INPUT_WIDTH-1:0]  pix_q;
  logic [CHANNELS*PIXEL_COUNT*DATA_WIDTH-1:0]   coef_q;
  logic                                         last_beat;
  logic                                         wd_expired;

`ifdef JPEG_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q;
  logic            err_timeout_q;
  // Watchdog fires during the final allowed WAIT cycle; the flag itself is raised one cycle earlier
  // so it is already visible while that last cycle is in progress.
  assign wd_expired  = (wd_q == WD_LAST);
  assign err_timeout = err_timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next drain position: walk indices of the current channel, then move to the next channel.
  always_comb begin
    idx_d  = idx_q + 1'b1;
    chan_d = chan_q;
    if (idx_q == LAST_PIX) begin
      idx_d  = '0;
      chan_d = chan_q + 1'b1;
    end
  end

  assign last_beat = m_valid_q && (chan_q == LAST_CHAN) && (idx_q == LAST_PIX);

  // Block sequencer FSM: all state, buffers and handshake outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FILL;
      s_ready_q     <= 1'b0;
      pipe_start_q  <= 1'b0;
      m_valid_q     <= 1'b0;
      pix_cnt_q     <= '0;
      idx_q         <= '0;
      chan_q        <= '0;
      blocks_q      <= '0;
      err_invalid_q <= 1'b0;
      pix_q         <= '0;
      coef_q        <= '0;
`ifdef JPEG_SEQ_WATCHDOG_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      pipe_start_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          // s_ready rises on the first FILL cycle after reset and stays up until the block is full.
          s_ready_q <= 1'b1;
          if (s_valid && s_ready_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
              pix_q[(c*PIXEL_COUNT + int'(pix_cnt_q))*INPUT_WIDTH +: INPUT_WIDTH]
                <= s_pixel[c*INPUT_WIDTH +: INPUT_WIDTH];
            end
            if (pix_cnt_q == LAST_PIX) begin
              pix_cnt_q    <= '0;
              s_ready_q    <= 1'b0;
              pipe_start_q <= 1'b1;
              state_q      <= ST_START;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
`ifdef JPEG_SEQ_WATCHDOG_EN
          wd_q <= '0;
          if (TIMEOUT_CYCLES == 1) err_timeout_q <= 1'b1;
`endif
        end
        ST_WAIT: begin
          if (wd_expired) begin
            // Pipeline never answered: drop the block and start collecting a new one.
            state_q   <= ST_FILL;
            s_ready_q <= 1'b1;
          end else if (pipe_done && pipe_valid) begin
            coef_q    <= pipe_coef;
            idx_q     <= '0;
            chan_q    <= '0;
            m_valid_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (pipe_done) begin
            err_invalid_q <= 1'b1;
            s_ready_q     <= 1'b1;
            state_q       <= ST_FILL;
          end
`ifdef JPEG_SEQ_WATCHDOG_EN
          else begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_LAST - 1'b1) err_timeout_q <= 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (last_beat) begin
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              idx_q     <= '0;
              chan_q    <= '0;
              blocks_q  <= blocks_q + 1'b1;
              state_q   <= ST_FILL;
            end else begin
              idx_q  <= idx_d;
              chan_q <= chan_d;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign pipe_start  = pipe_start_q;
  assign pipe_pix    = pix_q;
  assign m_valid     = m_valid_q;
  assign m_coef      = coef_q[(int'(chan_q)*PIXEL_COUNT + int'(idx_q))*DATA_WIDTH +: DATA_WIDTH];
  assign m_chan      = chan_q;
  assign m_index     = idx_q;
  assign m_last      = last_beat;
  assign blocks_done = blocks_q;
  assign err_invalid = err_invalid_q;

endmodule
